// File: rtl/pio_pkg.sv
// Shared definitions for the parametrised GPIO slave: register map, edge modes, bus request.
package pio_pkg;

    localparam logic [2:0] PIO_DATA = 3'd0;
    localparam logic [2:0] PIO_IN   = 3'd1;
    localparam logic [2:0] PIO_MASK = 3'd2;
    localparam logic [2:0] PIO_EDGE = 3'd3;
    localparam logic [2:0] PIO_SET  = 3'd4;
    localparam logic [2:0] PIO_CLR  = 3'd5;
    localparam logic [2:0] PIO_TOG  = 3'd6;

    localparam int EDGE_RISE  = 0;
    localparam int EDGE_FALL  = 1;
    localparam int EDGE_ANY   = 2;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } pio_req_t;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-stage input synchroniser plus per-bit edge detector on the last stage.
module pio_sync_edge #(
    parameter int DATA_WIDTH  = 27,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] s_o,
    output logic [DATA_WIDTH-1:0] det_o
);
    import pio_pkg::*;

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0]                  prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign det_o = s_o & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign det_o = ~s_o & prev_q;
        end else begin : g_any
            assign det_o = s_o ^ prev_q;
        end
    endgenerate

endmodule

// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO slave: output register with atomic set/clear/toggle, synchronised inputs,
// W1C edge capture and a maskable registered level interrupt. Zero read wait-states.
module pio_gpio_irq
    import pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 27,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    pio_req_t              req;
    logic [DATA_WIDTH-1:0] wd;
    logic                  unused_wd;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q,  cap_d;
    logic                  irq_q,  irq_d;
    logic [DATA_WIDTH-1:0] s, det, clr, rd;

    assign req.wr    = chipselect & ~write_n;
    assign req.addr  = address;
    assign req.wdata = writedata;
    assign wd        = req.wdata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    pio_sync_edge #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk  (clk),
        .rst_n(reset_n),
        .in_i (in_port),
        .s_o  (s),
        .det_o(det)
    );

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        clr    = '0;
        if (req.wr) begin
            case (req.addr)
                PIO_DATA: data_d = wd;
                PIO_MASK: mask_d = wd;
                PIO_EDGE: clr    = wd;
                PIO_SET:  data_d = data_q | wd;
                PIO_CLR:  data_d = data_q & ~wd;
                PIO_TOG:  data_d = data_q ^ wd;
                default:  ;
            endcase
        end
        // A fresh detection beats a simultaneous W1C on the same bit.
        cap_d = (cap_q & ~clr) | det;
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        rd = '0;
        case (address)
            PIO_DATA: rd = data_q;
            PIO_IN:   rd = s;
            PIO_MASK: rd = mask_q;
            PIO_EDGE: rd = cap_q;
            default:  rd = '0;
        endcase
    end

    assign readdata = 32'(rd);
    assign out_port = data_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Directed bench for pio_gpio_irq: rising-edge instance plus an any-edge instance on a shared bus.
module tb_pio_gpio_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [26:0] in_port;
    logic [31:0] readdata, readdata_a;
    logic [26:0] out_port, out_port_a;
    logic        irq, irq_a;
    logic [31:0] rd0, rda;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    pio_gpio_irq #(.DATA_WIDTH(27), .RESET_VALUE(27'h0000F0F), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    pio_gpio_irq #(.DATA_WIDTH(27), .RESET_VALUE(27'h0000F0F), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .out_port(out_port_a), .irq(irq_a)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        rd0 = readdata;
        rda = readdata_a;
        chipselect = 1'b0;
    endtask

    task automatic sb_push(input string t, input logic [31:0] e);
        sb_t it;
        it.tag = t;
        it.exp = e;
        sbq.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t it;
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %h expected <none>", obs);
            return;
        end
        it = sbq.pop_front();
        assert (obs === it.exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; in_port = '0;
        tick(2);

        // Reset state
        sb_push("rst_out", 32'h00000F0F);   sb_check({5'b0, out_port});
        sb_push("rst_irq", 32'h0);          sb_check({31'b0, irq});
        bus_rd(3'd0); sb_push("rst_rd0", 32'h00000F0F); sb_check(rd0);
        bus_rd(3'd2); sb_push("rst_rd2", 32'h0);        sb_check(rd0);
        bus_rd(3'd3); sb_push("rst_rd3", 32'h0);        sb_check(rd0);
        reset_n = 1'b1;
        tick(1);

        // Atomic output ops
        bus_wr(3'd0, 32'h07FFFFFF); sb_push("data_wr", 32'h07FFFFFF); sb_check({5'b0, out_port});
        bus_rd(3'd0); sb_push("data_rd", 32'h07FFFFFF); sb_check(rd0);
        bus_wr(3'd5, 32'h3);        sb_push("clr",  32'h07FFFFFC); sb_check({5'b0, out_port});
        bus_wr(3'd4, 32'h1);        sb_push("set",  32'h07FFFFFD); sb_check({5'b0, out_port});
        bus_wr(3'd6, 32'h04000000); sb_push("tog",  32'h03FFFFFD); sb_check({5'b0, out_port});
        bus_rd(3'd0); sb_push("tog_rd", 32'h03FFFFFD); sb_check(rd0);
        for (int a = 4; a < 8; a++) begin
            bus_rd(3'(a)); sb_push($sformatf("rd_addr%0d", a), 32'h0); sb_check(rd0);
        end
        bus_rd(3'd1); sb_push("in_idle", 32'h0); sb_check(rd0);

        // Truncation of write data
        bus_wr(3'd0, 32'hFFFFFFFF); sb_push("trunc_out", 32'h07FFFFFF); sb_check({5'b0, out_port});
        bus_rd(3'd0); sb_push("trunc_rd", 32'h07FFFFFF); sb_check(rd0);

        // Edge capture and irq
        bus_wr(3'd2, 32'h1);
        bus_rd(3'd2); sb_push("mask_rd", 32'h1); sb_check(rd0);
        in_port[1] = 1'b1;
        tick(4);
        bus_rd(3'd3); sb_push("cap_unmasked", 32'h2); sb_check(rd0);
        sb_push("irq_unmasked", 32'h0); sb_check({31'b0, irq});
        bus_wr(3'd3, 32'h2);
        bus_rd(3'd3); sb_push("cap_w1c", 32'h0); sb_check(rd0);

        in_port[0] = 1'b1;
        tick(1);
        bus_rd(3'd1); sb_push("in_clk1", 32'h2); sb_check(rd0);
        tick(1);
        bus_rd(3'd1); sb_push("in_clk2", 32'h3); sb_check(rd0);
        bus_rd(3'd3); sb_push("cap_clk2", 32'h0); sb_check(rd0);
        tick(1);
        bus_rd(3'd3); sb_push("cap_clk3", 32'h1); sb_check(rd0);
        sb_push("irq_clk3", 32'h0); sb_check({31'b0, irq});
        tick(1);
        sb_push("irq_clk4", 32'h1); sb_check({31'b0, irq});

        // Asynchronous reset mid-run
        #2 reset_n = 1'b0;
        #1;
        sb_push("mrst_out", 32'h00000F0F); sb_check({5'b0, out_port});
        sb_push("mrst_irq", 32'h0);        sb_check({31'b0, irq});
        bus_rd(3'd0); sb_push("mrst_rd0", 32'h00000F0F); sb_check(rd0);
        bus_rd(3'd2); sb_push("mrst_rd2", 32'h0);        sb_check(rd0);
        bus_rd(3'd3); sb_push("mrst_rd3", 32'h0);        sb_check(rd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);

        // Inputs still high, so they rise through the cleared chain again
        bus_wr(3'd2, 32'h1);
        tick(3);
        sb_push("rearm_irq", 32'h1); sb_check({31'b0, irq});
        bus_rd(3'd3); sb_push("rearm_cap", 32'h3); sb_check(rd0);
        bus_wr(3'd3, 32'h2);

        // W1C racing a fresh detection on bit0
        in_port[0] = 1'b0;
        tick(3);
        in_port[0] = 1'b1;
        tick(2);
        bus_wr(3'd3, 32'h1);
        bus_rd(3'd3); sb_push("race_cap", 32'h1); sb_check(rd0);
        sb_push("race_irq", 32'h1); sb_check({31'b0, irq});
        tick(1);
        sb_push("race_irq2", 32'h1); sb_check({31'b0, irq});
        bus_wr(3'd3, 32'h1);
        bus_rd(3'd3); sb_push("clr_cap", 32'h0); sb_check(rd0);
        sb_push("clr_irq_hold", 32'h1); sb_check({31'b0, irq});
        tick(1);
        sb_push("clr_irq_drop", 32'h0); sb_check({31'b0, irq});

        // Falling input: ignored in rise mode, captured in any-edge mode
        in_port[2] = 1'b1;
        tick(4);
        bus_wr(3'd3, 32'hFFFFFFFF);
        bus_rd(3'd3);
        sb_push("fall_pre_rise", 32'h0); sb_check(rd0);
        sb_push("fall_pre_any",  32'h0); sb_check(rda);
        in_port[2] = 1'b0;
        tick(4);
        bus_rd(3'd3);
        sb_push("fall_rise", 32'h0); sb_check(rd0);
        sb_push("fall_any",  32'h4); sb_check(rda);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
